// File: rtl/mips_register_file.sv
// mips_register_file: register file for the single-cycle MIPS datapath.
// There are 2**ADDR_WIDTH registers of DATA_WIDTH bits each.
// Register $0 always reads zero.
// Two read ports are combinational; one write port writes on the rising clk edge.
// rst_n is asynchronous and active-low, and clears every register.
// Optional feature: define REGFILE_BYPASS_EN for write-first forwarding.
//   With it, a read of the register being written returns WD3 in the same cycle.
//   The default build has no forwarding: reads return the pre-edge value.
module mips_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Flop array. A flop array, not a RAM macro, is needed so the asynchronous clear is legal.
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // A write is effective only out of reset, when enabled, and never to $0.
  logic wr_hit;
  assign wr_hit = rst_n && WE3 && (A3 != '0);

  // Index 0 is forced to zero here, independent of the flop contents.
  function automatic logic [DATA_WIDTH-1:0] read_reg(input logic [ADDR_WIDTH-1:0] addr);
    if (addr == '0) return '0;
    return regs[addr];
  endfunction

`ifdef REGFILE_BYPASS_EN
  // Write-first forwarding applies when this port reads the register being written.
  // wr_hit carries rst_n, so forwarding is suppressed during reset.
  function automatic logic bypass_hit(input logic [ADDR_WIDTH-1:0] addr);
    return wr_hit && (addr == A3);
  endfunction
`endif

  // Write port. Asynchronous clear takes priority over any write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      regs[A3] <= WD3;
    end
  end

  // Read ports, combinational with zero latency.
  always_comb begin
    RD1 = read_reg(A1);
    RD2 = read_reg(A2);
`ifdef REGFILE_BYPASS_EN
    if (bypass_hit(A1)) RD1 = WD3;
    if (bypass_hit(A2)) RD2 = WD3;
`endif
  end

endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: directed checks of mips_register_file.
// Expected values are held in a bench-side register model.
// Each expected value is pushed onto a queue when stimulus is driven.
// It is popped and compared when the DUT output is sampled.
module tb_mips_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] A1, A2, A3;
  logic [DW-1:0] WD3;
  logic          WE3;
  logic [DW-1:0] RD1, RD2;

  logic [DW-1:0] model [32];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  mips_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .A1(A1), .A2(A2), .A3(A3),
    .WD3(WD3), .WE3(WE3), .RD1(RD1), .RD2(RD2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [DW-1:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  function automatic logic [DW-1:0] mread(input logic [AW-1:0] a);
    return (a == '0) ? '0 : model[a];
  endfunction

  // Advance one rising edge and settle 1ns after it; the model mirrors a legal write.
  task automatic tick();
    @(posedge clk);
    if (rst_n && WE3 && A3 != '0) model[A3] = WD3;
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WE3 = 1'b1; A3 = a; WD3 = d;
    tick();
    WE3 = 1'b0;
  endtask

  task automatic read_pair(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    A1 = a; A2 = b;
    push(mread(a));
    push(mread(b));
    #1;
    check({tag, "_rd1"}, RD1);
    check({tag, "_rd2"}, RD2);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst_n = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

    // Reset state: registers read zero.
    #2;
    read_pair("reset_state", 5'd5, 5'd31);

    // A write attempted while reset is held is blocked.
    WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h12345678;
    @(posedge clk); #1;
    WE3 = 1'b0;
    read_pair("write_blocked_in_reset", 5'd6, 5'd6);

    // Deassert mid-cycle. The first write lands on the next rising edge.
    #2 rst_n = 1'b1;
    write_reg(5'd7, 32'hA5A5_0F0F);
    read_pair("first_write_after_reset", 5'd7, 5'd0);

    // Test 1: asynchronous clear mid-cycle after writing reg5.
    write_reg(5'd5, 32'hDEADBEEF);
    read_pair("reg5_written", 5'd5, 5'd7);
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    #1;
    read_pair("async_clear", 5'd5, 5'd7);

    // Reset asserted during a pending write: the clear wins.
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hCAFEF00D;
    @(posedge clk); #1;
    WE3 = 1'b0;
    #2 rst_n = 1'b1;
    #1;
    read_pair("clear_wins", 5'd5, 5'd5);

    // Test 2: basic write and read, same address on both ports.
    write_reg(5'd8, 32'h00001345);
    read_pair("write_read_8", 5'd8, 5'd8);

    // Test 3: writes to $0 are discarded.
    write_reg(5'd0, 32'hFFFFFFFF);
    read_pair("zero_protect", 5'd0, 5'd0);

    // Test 4: WE3 low changes nothing.
    WE3 = 1'b0; A3 = 5'd9; WD3 = 32'h0000C134;
    tick();
    read_pair("we_low", 5'd9, 5'd8);

    // Test 5: same-cycle read and write of reg3.
    write_reg(5'd3, 32'h00000001);
    WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h0000C134; A1 = 5'd3; A2 = 5'd8;
`ifdef REGFILE_BYPASS_EN
    push(32'h0000C134);
`else
    push(32'h00000001);
`endif
    push(32'h00001345);
    #1;
    check("raw_pre_edge_rd1", RD1);
    check("raw_other_port_rd2", RD2);
    tick();
    WE3 = 1'b0;
    read_pair("raw_post_edge", 5'd3, 5'd3);

    // Test 6: sweep all registers, then read complementary pairs.
    for (int i = 1; i < 32; i++) write_reg(AW'(i), DW'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) read_pair("sweep", AW'(i), AW'(31 - i));

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
